// File: rtl/cacheline_adapter.sv
// Bridges a 256-bit cache line port onto a 64-bit beat-oriented memory port.
// One line transaction at a time; memory-side protocol violations raise a sticky flag.
module cacheline_adapter #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       dfp_addr,
    input  logic                    dfp_read,
    input  logic                    dfp_write,
    input  logic [DATA_W*BEATS-1:0] dfp_wdata,
    output logic [DATA_W*BEATS-1:0] dfp_rdata,
    output logic                    dfp_resp,
    output logic [ADDR_W-1:0]       bmem_addr,
    output logic                    bmem_read,
    output logic                    bmem_write,
    output logic [DATA_W-1:0]       bmem_wdata,
    input  logic                    bmem_ready,
    input  logic [ADDR_W-1:0]       bmem_raddr,
    input  logic [DATA_W-1:0]       bmem_rdata,
    input  logic                    bmem_rvalid,
    output logic                    protocol_err
);
    localparam int LINE_W = DATA_W * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_REQ   = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR_BURST = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic              beat_ok;
    logic              beat_bad;
    logic              last_rd_beat;
    logic [LINE_W-1:0] wline;

    // A response beat is only usable in RD_WAIT and only when tagged with our line.
    assign beat_ok      = bmem_rvalid && (state_q == RD_WAIT) && (bmem_raddr == addr_q);
    assign beat_bad     = bmem_rvalid && !beat_ok;
    assign last_rd_beat = beat_ok && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                addr_d = dfp_addr & ~OFF_MASK;
                if (dfp_read) begin
                    state_d = RD_REQ;
                    if (dfp_write) begin
                        err_d = 1'b1;
                    end
                end else if (dfp_write) begin
                    state_d = WR_BURST;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (beat_ok) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (beat_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // Per-beat storage: latched write data, read capture buffer, and the
    // published read line, which only changes when a read finishes.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
            logic [DATA_W-1:0] wbeat_q;
            logic [DATA_W-1:0] cap_q;
            logic [DATA_W-1:0] rbeat_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wbeat_q <= '0;
                    cap_q   <= '0;
                    rbeat_q <= '0;
                end else begin
                    if (state_q == IDLE) begin
                        wbeat_q <= dfp_wdata[gi*DATA_W +: DATA_W];
                    end
                    if (beat_ok && (cnt_q == IDX)) begin
                        cap_q <= bmem_rdata;
                    end
                    if (last_rd_beat) begin
                        rbeat_q <= (cnt_q == IDX) ? bmem_rdata : cap_q;
                    end
                end
            end

            assign wline[gi*DATA_W +: DATA_W]     = wbeat_q;
            assign dfp_rdata[gi*DATA_W +: DATA_W] = rbeat_q;
        end
    endgenerate

    assign dfp_resp     = (state_q == DONE);
    assign bmem_read    = (state_q == RD_REQ);
    assign bmem_write   = (state_q == WR_BURST);
    assign bmem_addr    = (bmem_read || bmem_write) ? addr_q : '0;
    assign bmem_wdata   = bmem_write ? wline[cnt_q*DATA_W +: DATA_W] : '0;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench: stimulus queues expected memory requests, write beats and line
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cacheline_adapter;
    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         protocol_err;

    cacheline_adapter #(.DATA_W(64), .BEATS(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .protocol_err(protocol_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [255:0] exp_resp[$];
    logic [31:0]  exp_raddr[$];
    logic [63:0]  exp_wdata[$];
    logic [31:0]  exp_waddr[$];
    logic         exp_err   = 1'b0;
    logic [255:0] last_line = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Line read: memory returns line[64k+63:64k] as beat k.
    task automatic do_read(input logic [31:0] a, input logic [255:0] line, input int lows,
                           input int gapmax, input bit badtag, input bit also_write,
                           input int nbeats);
        logic [31:0] la;
        int reqcyc;
        bit acc;
        la = a & 32'hFFFF_FFE0;
        reqcyc = 0;
        acc = 1'b0;
        dfp_addr  = a;
        dfp_read  = 1'b1;
        dfp_write = also_write;
        dfp_wdata = rand256();
        exp_raddr.push_back(la);
        if (nbeats == 4) begin
            exp_resp.push_back(line);
            last_line = line;
        end
        if (also_write) exp_err = 1'b1;
        tick();
        dfp_addr = $urandom;
        for (int c = 0; c < 64 && !acc; c++) begin
            bmem_ready = (c >= lows);
            if (bmem_read) reqcyc++;
            acc = bmem_read && bmem_ready;
            tick();
            bmem_ready = 1'b0;
        end
        if (!acc) check("rd_req_timeout", 0, 1);
        check("rd_req_cycles", reqcyc, lows + 1);
        check("rd_req_drop", bmem_read, 0);
        for (int k = 0; k < nbeats; k++) begin
            int g;
            g = (gapmax == 0) ? 0 : $urandom_range(0, gapmax);
            if (badtag && k == 1 && g == 0) g = 1;
            for (int j = 0; j < g; j++) begin
                if (badtag && k == 1 && j == 0) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = la ^ 32'h40;
                    bmem_rdata  = {$urandom, $urandom};
                    exp_err     = 1'b1;
                end
                tick();
                bmem_rvalid = 1'b0;
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = la;
            bmem_rdata  = line[64*k +: 64];
            tick();
            bmem_rvalid = 1'b0;
        end
        if (nbeats == 4) begin
            check("rd_resp_latency", dfp_resp, 1);
            dfp_read  = 1'b0;
            dfp_write = 1'b0;
            tick();
            check("rd_resp_single", dfp_resp, 0);
            $display("read  addr=%h line=%h err=%0b", la, line, protocol_err);
        end
    endtask

    // Line write: ready follows pat[c] for c < patlen, random afterwards.
    task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                            input logic [15:0] pat, input int patlen);
        logic [31:0] la;
        int n;
        int c;
        la = a & 32'hFFFF_FFE0;
        n = 0;
        c = 0;
        dfp_addr  = a;
        dfp_wdata = line;
        dfp_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_wdata.push_back(line[64*k +: 64]);
            exp_waddr.push_back(la);
        end
        exp_resp.push_back(last_line);
        tick();
        dfp_addr  = $urandom;
        dfp_wdata = rand256();
        while (n < 4 && c < 200) begin
            bmem_ready = (c < patlen) ? pat[c] : 1'($urandom_range(0, 1));
            if (bmem_write && bmem_ready) n++;
            tick();
            c++;
        end
        bmem_ready = 1'b0;
        if (n < 4) check("wr_timeout", n, 4);
        if (patlen > 0) check("wr_cycles", c, patlen);
        check("wr_resp_latency", dfp_resp, 1);
        dfp_write = 1'b0;
        tick();
        $display("write addr=%h line=%h cycles=%0d", la, line, c);
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (bmem_read) begin
                    if (exp_raddr.size() == 0) check("rd_req_unexpected", 1, 0);
                    else begin
                        check("rd_req_addr", bmem_addr, exp_raddr[0]);
                        if (bmem_ready) void'(exp_raddr.pop_front());
                    end
                end
                if (bmem_write) begin
                    if (exp_wdata.size() == 0) check("wr_beat_unexpected", 1, 0);
                    else begin
                        check("wr_beat_data", bmem_wdata, exp_wdata[0]);
                        check("wr_beat_addr", bmem_addr, exp_waddr[0]);
                        if (bmem_ready) begin
                            void'(exp_wdata.pop_front());
                            void'(exp_waddr.pop_front());
                        end
                    end
                end
                if (dfp_resp) begin
                    if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
                    else begin
                        check("resp_rdata", dfp_rdata, exp_resp.pop_front());
                        check("resp_err", protocol_err, exp_err);
                    end
                end
            end
        end
    end

    task automatic flush_model();
        exp_resp.delete();
        exp_raddr.delete();
        exp_wdata.delete();
        exp_waddr.delete();
        exp_err   = 1'b0;
        last_line = '0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        flush_model();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        logic [255:0] l;
        rst = 1'b0;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        tick();
        tick();
        check("rst_resp", dfp_resp, 0);
        check("rst_bmem_read", bmem_read, 0);
        check("rst_bmem_write", bmem_write, 0);
        check("rst_rdata", dfp_rdata, 0);
        check("rst_err", protocol_err, 0);
        rst = 1'b1;
        tick();

        // Always-ready read, consecutive beats
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_read(32'h1000_0024, l, 0, 0, 1'b0, 1'b0, 4);
        check("rd1_err", protocol_err, 0);

        // Request stalled 3 cycles, gaps between beats
        do_read(32'h0BAD_F00D, rand256(), 3, 3, 1'b0, 1'b0, 4);

        // Write with ready 1,0,1,1,0,1
        l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_write(32'h2000_0048, l, 16'b10_1101, 6);

        // Mis-tagged beat in the middle of a read
        check("pre_badtag_err", protocol_err, 0);
        do_read(32'h3000_0100, rand256(), 1, 2, 1'b1, 1'b0, 4);
        check("badtag_err", protocol_err, 1);

        // Asynchronous reset after three beats of a read
        do_read(32'h4000_0040, rand256(), 0, 1, 1'b0, 1'b0, 3);
        rst = 1'b0;
        #1;
        check("arst_resp", dfp_resp, 0);
        check("arst_bmem_read", bmem_read, 0);
        check("arst_bmem_write", bmem_write, 0);
        check("arst_bmem_addr", bmem_addr, 0);
        check("arst_bmem_wdata", bmem_wdata, 0);
        check("arst_rdata", dfp_rdata, 0);
        check("arst_err", protocol_err, 0);
        flush_model();
        dfp_read = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        do_read(32'h5000_0060, rand256(), 0, 2, 1'b0, 1'b0, 4);

        // Stray response beat while idle
        check("pre_stray_err", protocol_err, 0);
        bmem_rvalid = 1'b1;
        bmem_raddr  = $urandom;
        bmem_rdata  = {$urandom, $urandom};
        tick();
        bmem_rvalid = 1'b0;
        exp_err = 1'b1;
        check("stray_err", protocol_err, 1);
        do_write(32'h6000_0000, rand256(), 16'hFFFF, 4);
        check("stray_sticky", protocol_err, 1);

        // Simultaneous read and write after a clean reset
        reset_pulse();
        check("pre_both_err", protocol_err, 0);
        do_read(32'h7000_0080, rand256(), 0, 1, 1'b0, 1'b1, 4);
        check("both_err", protocol_err, 1);

        // Randomised mix
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_read($urandom, rand256(), $urandom_range(0, 3), 3, 1'b0, 1'b0, 4);
            else
                do_write($urandom, rand256(), 16'h0, 0);
        end

        tick();
        check("resp_q_empty", exp_resp.size(), 0);
        check("rreq_q_empty", exp_raddr.size(), 0);
        check("wbeat_q_empty", exp_wdata.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
